oven_timer_multi: RTL and testbench
===================================

# oven_timer_multi

Parametrised multi-channel cook timer: the successor to the single-channel oven timer. Each channel counts down a loaded cook time in whole seconds, but only while its oven is preheated and the channel is not paused. Counting is driven by a one-cycle seconds strobe rather than a time-of-day compare, so there is no midnight or modulus wrap hazard. The block sits between the time-entry logic, the per-oven preheat detectors and the alarm/display logic.

## Interface
- `CHANNELS`, default 4: number of independent timers, ≥1.
- `TIME_W`, default 13: width of cook time and remaining time in seconds; maximum cook time is 2^TIME_W−1.

- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `secTick` in 1: one-cycle pulse, once per second, shared by all channels.
- `start` in CHANNELS: per-channel load/start request, level sampled each cycle.
- `cookTime` in CHANNELS*TIME_W: per-channel cook time; channel i occupies bits [i*TIME_W +: TIME_W].
- `preheated` in CHANNELS: per-channel oven-at-temperature flag.
- `pause` in CHANNELS: per-channel hold, level.
- `cancel` in CHANNELS: per-channel abort.
- `doneAck` in CHANNELS: per-channel alarm acknowledge.
- `remaining` out CHANNELS*TIME_W: per-channel seconds left, registered.
- `running` out CHANNELS: channel is in RUN.
- `done` out CHANNELS: channel is in DONE; sticky until acknowledged.
- `doneRise` out CHANNELS: one-cycle pulse on entry to DONE.
- `anyDone` out 1: registered OR of the next-state `done` bits; asserted the same cycle as `done`.

## Operation
- Each channel has an independent FSM: IDLE, WAIT_HEAT, RUN, PAUSE, DONE.
- Per-channel event priority, highest first: `cancel` > `start` > `doneAck` > `pause` > `preheated` > `secTick`.
- `cancel` in any state: go to IDLE with `remaining`=0. No `doneRise`.
- IDLE:
  - `start` with `cookTime`≠0 latches `remaining`=`cookTime`, then goes to RUN if `preheated`=1, otherwise to WAIT_HEAT.
  - `start` with `cookTime`=0 goes straight to DONE with `remaining`=0.
- `start` in any state other than IDLE is ignored; the load value is not re-sampled.
- WAIT_HEAT: go to RUN when `preheated`=1 (and `pause`=0). `pause` in WAIT_HEAT goes to PAUSE.
- RUN:
  - `pause`=1 goes to PAUSE.
  - Otherwise `preheated`=0 goes to WAIT_HEAT. This is new behaviour: the count holds while the oven recovers temperature.
  - Otherwise `secTick` decrements `remaining`. A tick that takes `remaining` from 1 to 0 goes to DONE.
- PAUSE: when `pause`=0, go to RUN if `preheated`=1, otherwise to WAIT_HEAT. `remaining` is frozen.
- DONE: `remaining`=0 and `done`=1 until `doneAck`, then go to IDLE.
- `remaining` never underflows. It is modified only by a load, a decrement in RUN, `cancel`, or reset.
- Channels never interact. Only `secTick` and `anyDone` are shared.

## Timing
- Reset (asynchronous assert, synchronous release on `clk`):
  - All channels go to IDLE.
  - `remaining`=0, `running`=0, `done`=0, `doneRise`=0, `anyDone`=0.
- All outputs are registered and reflect the state after the edge.
- Latency:
  - `start` at edge N gives `running`=1 (if preheated) and loaded `remaining` after edge N.
  - The final `secTick` at edge M gives `done`, `doneRise` and `anyDone` high after edge M.
  - `doneRise` drops after edge M+1.
- Entry cycle: a `secTick` coincident with the `start`, resume or preheat transition into RUN is not counted. Decrements happen only in cycles where the state is already RUN at the clock edge.
- Simultaneous `pause` and `secTick` in RUN: no decrement.
- Simultaneous `preheated` falling and `secTick` in RUN: no decrement.
- Simultaneous `cancel` and `doneAck` in DONE: go to IDLE (same outcome either way).
- Simultaneous `start` and `cancel`: `cancel` wins; the channel stays in IDLE with `remaining`=0.
- Reset asserted mid-count: immediate return to reset values with no `doneRise`.
- Maximum count 2^TIME_W−1 (8191 s at default) decrements without wrap.

## Test plan
- Basic count, CHANNELS=4, TIME_W=13, ch0 preheated: `start` with `cookTime`=3, then 3 `secTick` pulses 10 cycles apart.
  - `remaining` steps 3→2→1→0.
  - `done[0]` and `anyDone` rise after the 3rd tick.
  - `doneRise[0]` is high for exactly 1 cycle.
  - `doneAck` returns ch0 to IDLE with `done`=0.
- Preheat gating: ch1 starts with `cookTime`=5 and `preheated`=0.
  - WAIT_HEAT; 4 ticks leave `remaining`=5.
  - Raise `preheated`; 2 ticks give 3.
  - Drop `preheated`; 2 ticks leave 3.
  - Raise `preheated` again; 3 ticks give DONE.
- Pause and coincidence: ch2 counting from 10.
  - `pause` asserted in the same cycle as a tick holds at 10.
  - 3 ticks while paused leave 10.
  - Release `pause`; a tick in the same cycle as the release still reads 10; the next tick gives 9.
- Cancel and restart: ch3 at `remaining`=7.
  - `cancel` gives IDLE, 0, no `doneRise`.
  - `start` with `cookTime`=0 gives `done` and `doneRise` on the next edge.
  - `start` while in DONE is ignored.
- Channel independence and maximum value:
  - All four channels start together with 8191, 1, 2 and 0.
  - Only the expected channels finish on their ticks; ch0 after 1 tick reads 8190.
  - `anyDone` tracks the OR of `done`.
- Async reset mid-count: drop `reset_n` between clock edges while ch0=4 is RUN.
  - Outputs go to reset values without waiting for a clock edge.
  - After release, ticks have no effect until a new `start`.

Source files
------------

// File: rtl/oven_timer_multi.sv
// Multi-channel cook timer: each channel counts a loaded time down on secTick while preheated and not paused.
// Latency: all outputs registered, valid the cycle after the causing edge; anyDone aligned with done.
// Backpressure: none; level inputs are sampled every cycle, and secTick pulses are dropped unless the channel is already in RUN.
//
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   secTick             shared one-cycle seconds strobe
//   start/cancel/pause  per-channel control (cancel > start > doneAck > pause > preheated > secTick)
//   preheated, doneAck  per-channel oven-ready flag and alarm acknowledge
//   cookTime            per-channel load value, channel i at [i*TIME_W +: TIME_W]
//   remaining           per-channel seconds left, same packing as cookTime
//   running/done        channel is in RUN / DONE
//   doneRise            one-cycle pulse on entry to DONE
//   anyDone             OR of all done bits
module oven_timer_multi #(
  parameter int CHANNELS = 4,
  parameter int TIME_W   = 13
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         secTick,
  input  logic [CHANNELS-1:0]          start,
  input  logic [CHANNELS*TIME_W-1:0]   cookTime,
  input  logic [CHANNELS-1:0]          preheated,
  input  logic [CHANNELS-1:0]          pause,
  input  logic [CHANNELS-1:0]          cancel,
  input  logic [CHANNELS-1:0]          doneAck,
  output logic [CHANNELS*TIME_W-1:0]   remaining,
  output logic [CHANNELS-1:0]          running,
  output logic [CHANNELS-1:0]          done,
  output logic [CHANNELS-1:0]          doneRise,
  output logic                         anyDone
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_HEAT = 3'd1,
    S_RUN       = 3'd2,
    S_PAUSE     = 3'd3,
    S_DONE      = 3'd4
  } state_e;

  state_e              state_q [CHANNELS];
  state_e              state_d [CHANNELS];
  logic [TIME_W-1:0]   rem_q   [CHANNELS];
  logic [TIME_W-1:0]   rem_d   [CHANNELS];
  logic [CHANNELS-1:0] running_q;
  logic [CHANNELS-1:0] done_q;
  logic [CHANNELS-1:0] done_rise_q;
  logic [CHANNELS-1:0] done_d;
  logic                any_done_q;

  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      state_d[i] = state_q[i];
      rem_d[i]   = rem_q[i];
      if (cancel[i]) begin
        state_d[i] = S_IDLE;
        rem_d[i]   = '0;
      end else begin
        case (state_q[i])
          S_IDLE: begin
            if (start[i]) begin
              if (cookTime[i*TIME_W +: TIME_W] != '0) begin
                rem_d[i]   = cookTime[i*TIME_W +: TIME_W];
                // start outranks pause, so a preheated oven goes straight to RUN
                state_d[i] = preheated[i] ? S_RUN : S_WAIT_HEAT;
              end else begin
                rem_d[i]   = '0;
                state_d[i] = S_DONE;
              end
            end
          end
          S_WAIT_HEAT: begin
            if (pause[i])          state_d[i] = S_PAUSE;
            else if (preheated[i]) state_d[i] = S_RUN;
          end
          S_RUN: begin
            // a tick is only counted when nothing else moves the channel out of RUN
            if (pause[i])           state_d[i] = S_PAUSE;
            else if (!preheated[i]) state_d[i] = S_WAIT_HEAT;
            else if (secTick && rem_q[i] != '0) begin
              rem_d[i] = rem_q[i] - TIME_W'(1);
              if (rem_q[i] == TIME_W'(1)) state_d[i] = S_DONE;
            end
          end
          S_PAUSE: begin
            if (!pause[i]) state_d[i] = preheated[i] ? S_RUN : S_WAIT_HEAT;
          end
          S_DONE: begin
            if (doneAck[i]) state_d[i] = S_IDLE;
          end
          default: begin
            state_d[i] = S_IDLE;
            rem_d[i]   = '0;
          end
        endcase
      end
      done_d[i] = (state_d[i] == S_DONE);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < CHANNELS; i++) begin
        state_q[i] <= S_IDLE;
        rem_q[i]   <= '0;
      end
      running_q   <= '0;
      done_q      <= '0;
      done_rise_q <= '0;
      any_done_q  <= 1'b0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        state_q[i]     <= state_d[i];
        rem_q[i]       <= rem_d[i];
        running_q[i]   <= (state_d[i] == S_RUN);
        done_q[i]      <= done_d[i];
        done_rise_q[i] <= done_d[i] && (state_q[i] != S_DONE);
      end
      any_done_q <= |done_d;
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_rem
    assign remaining[g*TIME_W +: TIME_W] = rem_q[g];
  end

  assign running  = running_q;
  assign done     = done_q;
  assign doneRise = done_rise_q;
  assign anyDone  = any_done_q;

endmodule

// File: tb/tb_oven_timer_multi.sv
module tb_oven_timer_multi;
  localparam int CH = 4;
  localparam int TW = 13;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             secTick;
  logic [CH-1:0]    start, preheated, pause, cancel, doneAck;
  logic [CH*TW-1:0] cookTime;
  logic [CH*TW-1:0] remaining;
  logic [CH-1:0]    running, done, doneRise;
  logic             anyDone;

  int n_pass  = 0;
  int n_total = 0;

  // behavioural reference: a channel is "loaded" (counting toward zero) or "finished";
  // whether it is running follows from the last sampled pause/preheat levels
  bit          m_act  [CH];
  bit          m_fin  [CH];
  bit          m_run  [CH];
  bit          m_rise [CH];
  int unsigned m_rem  [CH];

  typedef struct {
    logic st; logic [TW-1:0] ct; logic pre, pau, can, ack, tick;
    logic [TW-1:0] rem; logic run, dn, rise;
  } vec_t;
  vec_t tbl[$];

  oven_timer_multi #(.CHANNELS(CH), .TIME_W(TW)) dut (
    .clk(clk), .reset_n(reset_n), .secTick(secTick), .start(start),
    .cookTime(cookTime), .preheated(preheated), .pause(pause),
    .cancel(cancel), .doneAck(doneAck), .remaining(remaining),
    .running(running), .done(done), .doneRise(doneRise), .anyDone(anyDone)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    secTick = 0; start = '0; cookTime = '0; pause = '0; cancel = '0; doneAck = '0;
  endtask

  function automatic logic [TW-1:0] rem_of(input int c);
    return remaining[c*TW +: TW];
  endfunction

  function automatic vec_t v(input logic st, input int ct, input logic pre, pau, can, ack, tick,
                             input int rem, input logic run, dn, rise);
    vec_t r;
    r.st = st; r.ct = TW'(ct); r.pre = pre; r.pau = pau; r.can = can; r.ack = ack; r.tick = tick;
    r.rem = TW'(rem); r.run = run; r.dn = dn; r.rise = rise;
    return r;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      m_act[c] = 0; m_fin[c] = 0; m_run[c] = 0; m_rise[c] = 0; m_rem[c] = 0;
    end
  endtask

  // evaluates one clock edge from the current input levels
  task automatic model_edge();
    for (int c = 0; c < CH; c++) begin
      int unsigned ct;
      ct = cookTime[c*TW +: TW];
      m_rise[c] = 0;
      if (cancel[c]) begin
        m_act[c] = 0; m_fin[c] = 0; m_run[c] = 0; m_rem[c] = 0;
      end else if (m_fin[c]) begin
        if (doneAck[c]) m_fin[c] = 0;
      end else if (!m_act[c]) begin
        if (start[c]) begin
          if (ct != 0) begin
            m_act[c] = 1; m_rem[c] = ct; m_run[c] = preheated[c];
          end else begin
            m_fin[c] = 1; m_rise[c] = 1;
          end
        end
      end else begin
        if (m_run[c] && !pause[c] && preheated[c] && secTick) m_rem[c]--;
        if (m_rem[c] == 0) begin
          m_act[c] = 0; m_fin[c] = 1; m_rise[c] = 1; m_run[c] = 0;
        end else begin
          m_run[c] = !pause[c] && preheated[c];
        end
      end
    end
  endtask

  task automatic check_model(input int cyc);
    bit any;
    any = 0;
    for (int c = 0; c < CH; c++) begin
      check($sformatf("rand cyc%0d ch%0d {rem,run,done,rise}", cyc, c),
            {rem_of(c), running[c], done[c], doneRise[c]},
            {TW'(m_rem[c]), m_run[c], m_fin[c], m_rise[c]});
      any |= m_fin[c];
    end
    check($sformatf("rand cyc%0d anyDone", cyc), 32'(anyDone), 32'(any));
  endtask

  initial begin
    reset_n = 0; preheated = '0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    check("reset outputs", {remaining, running, done, doneRise, anyDone}, '0);
    @(negedge clk) reset_n = 1;
    #1;

    // ch0 directed vectors: start, ct, pre, pause, cancel, ack, tick -> rem, run, done, rise
    // basic count
    tbl.push_back(v(1, 3, 1,0,0,0,0,  3, 1,0,0));
    tbl.push_back(v(0, 0, 1,0,0,0,0,  3, 1,0,0));
    tbl.push_back(v(0, 0, 1,0,0,0,1,  2, 1,0,0));
    tbl.push_back(v(0, 0, 1,0,0,0,1,  1, 1,0,0));
    tbl.push_back(v(0, 0, 1,0,0,0,1,  0, 0,1,1));
    tbl.push_back(v(0, 0, 1,0,0,0,0,  0, 0,1,0));
    tbl.push_back(v(0, 0, 1,0,0,1,0,  0, 0,0,0));
    // preheat gating
    tbl.push_back(v(1, 5, 0,0,0,0,0,  5, 0,0,0));
    tbl.push_back(v(0, 0, 0,0,0,0,1,  5, 0,0,0));
    tbl.push_back(v(0, 0, 0,0,0,0,1,  5, 0,0,0));
    tbl.push_back(v(0, 0, 1,0,0,0,0,  5, 1,0,0));
    tbl.push_back(v(0, 0, 1,0,0,0,1,  4, 1,0,0));
    tbl.push_back(v(0, 0, 1,0,0,0,1,  3, 1,0,0));
    tbl.push_back(v(0, 0, 0,0,0,0,1,  3, 0,0,0));
    tbl.push_back(v(0, 0, 0,0,0,0,1,  3, 0,0,0));
    tbl.push_back(v(0, 0, 1,0,0,0,1,  3, 1,0,0));
    tbl.push_back(v(0, 0, 1,0,0,0,1,  2, 1,0,0));
    tbl.push_back(v(0, 0, 1,0,0,0,1,  1, 1,0,0));
    tbl.push_back(v(0, 0, 1,0,0,0,1,  0, 0,1,1));
    tbl.push_back(v(0, 0, 1,0,0,1,0,  0, 0,0,0));
    // pause and coincidence
    tbl.push_back(v(1,10, 1,0,0,0,0, 10, 1,0,0));
    tbl.push_back(v(0, 0, 1,1,0,0,1, 10, 0,0,0));
    tbl.push_back(v(0, 0, 1,1,0,0,1, 10, 0,0,0));
    tbl.push_back(v(0, 0, 1,1,0,0,1, 10, 0,0,0));
    tbl.push_back(v(0, 0, 1,0,0,0,1, 10, 1,0,0));
    tbl.push_back(v(0, 0, 1,0,0,0,1,  9, 1,0,0));
    // cancel, zero-length start, start ignored in DONE
    tbl.push_back(v(0, 0, 1,0,1,0,0,  0, 0,0,0));
    tbl.push_back(v(1, 0, 1,0,0,0,0,  0, 0,1,1));
    tbl.push_back(v(1, 9, 1,0,0,0,1,  0, 0,1,0));
    tbl.push_back(v(0, 0, 1,0,1,1,0,  0, 0,0,0));
    tbl.push_back(v(1, 6, 1,0,1,0,0,  0, 0,0,0));
    // start outranks pause; pause then takes effect
    tbl.push_back(v(1, 2, 1,1,0,0,1,  2, 1,0,0));
    tbl.push_back(v(0, 0, 1,1,0,0,1,  2, 0,0,0));
    tbl.push_back(v(0, 0, 1,0,1,0,0,  0, 0,0,0));

    for (int i = 0; i < tbl.size(); i++) begin
      start[0] = tbl[i].st; cookTime[TW-1:0] = tbl[i].ct; preheated[0] = tbl[i].pre;
      pause[0] = tbl[i].pau; cancel[0] = tbl[i].can; doneAck[0] = tbl[i].ack;
      secTick = tbl[i].tick;
      step();
      check($sformatf("vec%0d ch0 {rem,run,done,rise}", i),
            {rem_of(0), running[0], done[0], doneRise[0]},
            {tbl[i].rem, tbl[i].run, tbl[i].dn, tbl[i].rise});
      check($sformatf("vec%0d anyDone", i), 32'(anyDone), 32'(tbl[i].dn));
    end
    clear_inputs();

    // independence and maximum value
    preheated = '1;
    start = '1;
    cookTime = {TW'(0), TW'(2), TW'(1), TW'(8191)};
    step();
    start = '0; cookTime = '0;
    check("indep load rem", remaining, {TW'(0), TW'(2), TW'(1), TW'(8191)});
    check("indep load done/rise", {done, doneRise, anyDone}, {4'b1000, 4'b1000, 1'b1});
    secTick = 1; step();
    check("indep tick1 rem", remaining, {TW'(0), TW'(1), TW'(0), TW'(8190)});
    check("indep tick1 done/rise/run", {done, doneRise, running}, {4'b1010, 4'b0010, 4'b0101});
    doneAck = 4'b1010; step();
    doneAck = '0;
    check("indep tick2 done/rise", {done, doneRise, anyDone}, {4'b0100, 4'b0100, 1'b1});
    check("indep tick2 ch0", 32'(rem_of(0)), 32'd8189);
    secTick = 0; cancel = '1; step();
    cancel = '0;
    check("indep cleared anyDone", {anyDone, done}, 5'b0);

    // asynchronous reset mid-count
    start[0] = 1; cookTime[TW-1:0] = TW'(4); step();
    start = '0; cookTime = '0;
    check("pre-reset ch0", {rem_of(0), running[0]}, {TW'(4), 1'b1});
    #2 reset_n = 0;
    #1;
    check("async reset no edge", {remaining, running, done, doneRise, anyDone}, '0);
    @(negedge clk) reset_n = 1;
    secTick = 1;
    repeat (3) step();
    secTick = 0;
    check("post-reset ticks idle", {remaining, running, done, doneRise}, '0);

    // randomized run against the reference model
    model_reset();
    preheated = '0; clear_inputs();
    for (int cyc = 0; cyc < 4000; cyc++) begin
      secTick = ($urandom_range(3) == 0);
      for (int c = 0; c < CH; c++) begin
        start[c]   = ($urandom_range(7) == 0);
        cookTime[c*TW +: TW] = TW'($urandom_range(12));
        cancel[c]  = ($urandom_range(59) == 0);
        doneAck[c] = ($urandom_range(5) == 0);
        if ($urandom_range(7) == 0) pause[c] = ~pause[c];
        if ($urandom_range(9) == 0) preheated[c] = ~preheated[c];
      end
      model_edge();
      step();
      check_model(cyc);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
